// File: rtl/mem_arbiter.sv
// Round-robin arbiter granting one shared memory port to a fetch and a data requester,
// with a per-access wait-cycle timeout that aborts the access and flags err.
module mem_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic        if_ack,
    output logic [15:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        d_ack,
    output logic [15:0] d_rdata,
    output logic        addr_sel,
    output logic        mem_en,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_r,
    output logic        err,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;

    localparam logic [7:0] TLIM = 8'(TIMEOUT - 1);

    state_t     state, nstate;
    logic       last_f;     // 1 = fetch was granted most recently
    logic       we_q;
    logic [7:0] wcnt;
    logic       f_el, d_el, gnt_f, gnt_d, done, tmo;

    always_comb begin
        // a requester being acked this cycle is still holding req from the finished access
        f_el   = if_req & ~if_ack;
        d_el   = d_req & ~d_ack;
        gnt_f  = 1'b0;
        gnt_d  = 1'b0;
        done   = (state != IDLE) & mem_r;
        tmo    = (state != IDLE) & ~mem_r & (wcnt == TLIM);
        nstate = state;
        mem_en = (state != IDLE);
        busy   = (state != IDLE);
        mem_we = (state == DATA) & we_q;
        case (state)
            IDLE: begin
                if (f_el && (!d_el || !last_f)) begin
                    gnt_f  = 1'b1;
                    nstate = FETCH;
                end else if (d_el) begin
                    gnt_d  = 1'b1;
                    nstate = DATA;
                end
            end
            FETCH, DATA: if (done || tmo) nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= nstate;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_f    <= 1'b0;
            we_q      <= 1'b0;
            wcnt      <= 8'd0;
            addr_sel  <= 1'b0;
            mem_addr  <= 16'd0;
            mem_wdata <= 16'd0;
            if_ack    <= 1'b0;
            d_ack     <= 1'b0;
            err       <= 1'b0;
            if_rdata  <= 16'd0;
            d_rdata   <= 16'd0;
        end else begin
            if_ack <= 1'b0;
            d_ack  <= 1'b0;
            err    <= 1'b0;
            if (gnt_f || gnt_d) begin
                wcnt     <= 8'd0;
                last_f   <= gnt_f;
                addr_sel <= gnt_f;
                mem_addr <= gnt_f ? if_addr : d_addr;
                if (gnt_d) begin
                    we_q      <= d_we;
                    mem_wdata <= d_wdata;
                end
            end
            if (state != IDLE) begin
                if (!mem_r) wcnt <= wcnt + 8'd1;
                if (done || tmo) begin
                    if_ack <= (state == FETCH);
                    d_ack  <= (state == DATA);
                    err    <= tmo;
                end
                if (done && state == FETCH)          if_rdata <= mem_rdata;
                if (done && state == DATA && !we_q)  d_rdata  <= mem_rdata;
            end
        end
    end

endmodule
